// File: rtl/instr_image_loader.sv
// rtl/instr_image_loader.sv - encodes RV32I/F field descriptors and writes them to instruction memory
// Holds the core in reset until a complete image has been written.
module instr_image_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                last_q, last_d;

  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                imm_fits12;
  logic [ADDR_W:0]     count_inc;

  assign imm_fits12 = (in_imm[12] == in_imm[11]);
  assign count_inc  = count_q + (ADDR_W+1)'(1);

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_fmt)
      3'b000: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        enc_legal = imm_fits12;
      end
      3'b001: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        enc_legal = imm_fits12;
      end
      3'b010: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'b011: begin
        // Branch offsets are halfword-aligned, so imm[0] has no slot in the word.
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], 7'b1100011};
        enc_legal = ~in_imm[0];
      end
      3'b100: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        enc_legal = imm_fits12;
      end
      3'b101: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000111};
        enc_legal = imm_fits12;
      end
      3'b110: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100111};
        enc_legal = imm_fits12;
      end
      default: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b1010011};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    err_d       = err_q;
    last_d      = last_q;
    in_ready    = (state_q == LOAD);
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LOAD;
          addr_d     = '0;
          count_d    = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (enc_legal) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = enc_word;
            last_d      = in_last;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_inc;
        if (last_q) begin
          state_d    = DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else if (count_inc == DEPTH_C) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_q      <= last_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule
